// File: rtl/pr_aw_pkg.sv
// -----------------------------------------------------------------------------
// pr_aw_pkg
// Shared types and constants for the AW write-snoop unit.
//   snoop_st_t : snoop FSM states
//   ERR_*      : sticky error codes reported on errorCode
// -----------------------------------------------------------------------------
package pr_aw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_FLUSH,
      ST_FORWARD
   } snoop_st_t;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_FLUSH_TO  = 3'd1;
   localparam logic [2:0] ERR_ADDR_WRAP = 3'd2;

endpackage

// File: rtl/pr_aw_snoop_if.sv
// -----------------------------------------------------------------------------
// pr_aw_snoop_if
// AXI write-address channel subset (valid/ready handshake plus addr/len/id).
//   master modport : drives valid, addr, len, id; samples ready
//   slave modport  : samples valid, addr, len, id; drives ready
// -----------------------------------------------------------------------------
interface pr_aw_snoop_if #(
   parameter int ADDR_BITS       = 16,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int TID_WIDTH       = 8
);
   logic                       valid;
   logic                       ready;
   logic [ADDR_BITS-1:0]       addr;
   logic [BURST_LEN_WIDTH-1:0] len;
   logic [TID_WIDTH-1:0]       id;

   modport master (output valid, addr, len, id, input ready);
   modport slave  (input valid, addr, len, id, output ready);
endinterface

// File: rtl/pr_range_overlap.sv
// -----------------------------------------------------------------------------
// pr_range_overlap
// Combinational test whether inclusive intervals [a_lo,a_hi] and [b_lo,b_hi]
// share at least one address.
//   a_lo, a_hi : first interval bounds (inclusive)
//   b_lo, b_hi : second interval bounds (inclusive)
//   overlap    : 1 when the intervals intersect
// -----------------------------------------------------------------------------
module pr_range_overlap #(
   parameter int ADDR_BITS = 16
) (
   input  logic [ADDR_BITS-1:0] a_lo,
   input  logic [ADDR_BITS-1:0] a_hi,
   input  logic [ADDR_BITS-1:0] b_lo,
   input  logic [ADDR_BITS-1:0] b_hi,
   output logic                 overlap
);
   assign overlap = (a_lo <= b_hi) && (a_hi >= b_lo);
endmodule

// File: rtl/pr_aw_snoop.sv
// -----------------------------------------------------------------------------
// pr_aw_snoop
// Write-snoop unit between the AW slave port and the DRAM AW channel. Each
// accepted AW burst is compared against the prefetched windows of STREAM_NUM
// streams; overlapping streams are asked to flush and the AW is held until all
// of them acknowledge (or the flush timeout expires), then forwarded.
//   clk, resetN      : clock, synchronous active-low reset
//   en               : snoop enable (0 = never flush, AW still forwarded)
//   s_aw             : slave AW channel (one burst in flight at a time)
//   m_aw             : master AW channel, registered copy of the accepted AW
//   str_valid        : stream i holds prefetched data
//   str_lo, str_hi   : inclusive window of stream i, slice [i*ADDR_BITS +: ADDR_BITS]
//   flush_req        : level request to stream i to drop its data
//   flush_ack        : stream i finished flushing (pulse is enough)
//   crs_flushTimeout : max cycles to wait for acks, 0 = forever
//   errorCode        : sticky error (ERR_FLUSH_TO / ERR_ADDR_WRAP)
// -----------------------------------------------------------------------------
module pr_aw_snoop
   import pr_aw_pkg::*;
#(
   parameter int ADDR_BITS            = 16,
   parameter int TID_WIDTH            = 8,
   parameter int BURST_LEN_WIDTH      = 8,
   parameter int LOG_BLOCK_DATA_BYTES = 0,
   parameter int STREAM_NUM           = 4,
   parameter int FLUSH_TO_WIDTH       = 10
) (
   input  logic                            clk,
   input  logic                            resetN,
   input  logic                            en,
   pr_aw_snoop_if.slave                    s_aw,
   pr_aw_snoop_if.master                   m_aw,
   input  logic [STREAM_NUM-1:0]           str_valid,
   input  logic [STREAM_NUM*ADDR_BITS-1:0] str_lo,
   input  logic [STREAM_NUM*ADDR_BITS-1:0] str_hi,
   output logic [STREAM_NUM-1:0]           flush_req,
   input  logic [STREAM_NUM-1:0]           flush_ack,
   input  logic [FLUSH_TO_WIDTH-1:0]       crs_flushTimeout,
   output logic [2:0]                      errorCode
);
   localparam int EW = ADDR_BITS + 1;

   snoop_st_t                  state, state_d;
   logic [ADDR_BITS-1:0]       addr_q;
   logic [BURST_LEN_WIDTH-1:0] len_q;
   logic [TID_WIDTH-1:0]       id_q;
   logic [STREAM_NUM-1:0]      pend_q, pend_d, hit;
   logic [STREAM_NUM-1:0]      flush_req_q, flush_req_d;
   logic [FLUSH_TO_WIDTH-1:0]  cnt_q, cnt_d;
   logic [2:0]                 err_q, err_d;
   logic                       m_valid_q, m_valid_d;
   logic                       accept;
   logic [EW-1:0]              end_full;
   logic [ADDR_BITS-1:0]       end_addr;
   logic                       wrap;

   assign s_aw.ready = (state == ST_IDLE) && resetN;
   assign accept     = s_aw.valid && (state == ST_IDLE);

   assign m_aw.valid = m_valid_q;
   assign m_aw.addr  = addr_q;
   assign m_aw.len   = len_q;
   assign m_aw.id    = id_q;
   assign flush_req  = flush_req_q;
   assign errorCode  = err_q;

   // Last byte of the burst, one bit wider so a wrap past the top of the
   // address space shows up as a carry; a wrapped burst is clamped to the top.
   assign end_full = {1'b0, addr_q}
                   + ((EW'(len_q) + EW'(1)) << LOG_BLOCK_DATA_BYTES)
                   - EW'(1);
   assign wrap     = end_full[ADDR_BITS];
   assign end_addr = wrap ? '1 : end_full[ADDR_BITS-1:0];

   for (genvar i = 0; i < STREAM_NUM; i++) begin : g_str
      logic ovl;

      pr_range_overlap #(.ADDR_BITS(ADDR_BITS)) u_ovl (
         .a_lo    (addr_q),
         .a_hi    (end_addr),
         .b_lo    (str_lo[i*ADDR_BITS +: ADDR_BITS]),
         .b_hi    (str_hi[i*ADDR_BITS +: ADDR_BITS]),
         .overlap (ovl)
      );

      assign hit[i] = en && str_valid[i] && ovl;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!resetN) state <= ST_IDLE;
      else         state <= state_d;
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      m_valid_d   = 1'b0;
      flush_req_d = '0;

      unique case (state)
         ST_IDLE: begin
            if (accept) state_d = ST_CHECK;
         end

         ST_CHECK: begin
            pend_d = hit;
            cnt_d  = '0;
            if (wrap && (err_q == ERR_NONE)) err_d = ERR_ADDR_WRAP;
            state_d = (hit == '0) ? ST_FORWARD : ST_FLUSH;
         end

         ST_FLUSH: begin
            // flush_req follows pend one cycle late, so a stream keeps seeing
            // its request for the cycle after its ack is sampled.
            flush_req_d = pend_q;
            pend_d      = pend_q & ~flush_ack;
            cnt_d       = cnt_q + FLUSH_TO_WIDTH'(1);
            // An ack that empties pend wins over a coincident timeout.
            if (pend_d == '0) begin
               state_d = ST_FORWARD;
            end else if ((crs_flushTimeout != '0) && (cnt_d == crs_flushTimeout)) begin
               pend_d  = '0;
               if (err_q == ERR_NONE) err_d = ERR_FLUSH_TO;
               state_d = ST_FORWARD;
            end
         end

         ST_FORWARD: begin
            // m_aw_valid rises one cycle after entering FORWARD and drops on
            // the handshake edge.
            m_valid_d = !(m_valid_q && m_aw.ready);
            if (m_valid_q && m_aw.ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the held AW fields are reset too, so m_aw_* reads as zero after
   // reset rather than stale data from an interrupted transfer.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         addr_q      <= '0;
         len_q       <= '0;
         id_q        <= '0;
         pend_q      <= '0;
         cnt_q       <= '0;
         err_q       <= ERR_NONE;
         m_valid_q   <= 1'b0;
         flush_req_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= s_aw.addr;
            len_q  <= s_aw.len;
            id_q   <= s_aw.id;
         end
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         m_valid_q   <= m_valid_d;
         flush_req_q <= flush_req_d;
      end
   end

endmodule
